// File: rtl/multicycle_control.sv
// Control sequencer for the multicycle datapath: fetch, decode, execute,
// memory access and write-back, plus retired-instruction count and halt.
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       insType,
    input  logic [4:0]       func,
    input  logic             stop,
    input  logic             zero,
    input  logic             memAck,
    output logic             memReq,
    output logic             memRead,
    output logic             memWrite,
    output logic             irWrite,
    output logic             pcWrite,
    output logic             regWrite,
    output logic [1:0]       pcSrc,
    output logic             aluSrcB,
    output logic [1:0]       aluOp,
    output logic [1:0]       wbSel,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] INS_R = 2'b00;
    localparam logic [1:0] INS_I = 2'b01;
    localparam logic [1:0] INS_J = 2'b10;
    localparam logic [1:0] INS_S = 2'b11;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             is_load_q, is_load_d;
    logic             complete;

    // State, retired counter and load/store direction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
            is_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            is_load_q <= is_load_d;
        end
    end

    // Next-state and strobe decode; the load flag is captured in EXEC so
    // MEM and WB know the direction and write-back source.
    always_comb begin
        state_d   = state_q;
        retired_d = retired_q;
        is_load_d = is_load_q;
        complete  = 1'b0;
        memReq    = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        irWrite   = 1'b0;
        pcWrite   = 1'b0;
        regWrite  = 1'b0;
        pcSrc     = 2'b00;
        aluSrcB   = 1'b0;
        aluOp     = 2'b00;
        wbSel     = 2'b00;
        halted    = 1'b0;

        case (state_q)
            S_FETCH: begin
                memReq  = 1'b1;
                memRead = 1'b1;
                if (memAck) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    pcSrc   = 2'b00;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                is_load_d = 1'b0;
                case (insType)
                    INS_R: begin
                        if (func <= 5'd3) begin
                            aluOp   = 2'b10;
                            aluSrcB = 1'b0;
                            state_d = S_WB;
                        end else begin
                            complete = 1'b1;
                        end
                    end
                    INS_I: begin
                        if (func <= 5'd1) begin
                            aluOp   = 2'b10;
                            aluSrcB = 1'b1;
                            state_d = S_WB;
                        end else if (func <= 5'd3) begin
                            aluOp     = 2'b00;
                            aluSrcB   = 1'b1;
                            is_load_d = (func == 5'd2);
                            state_d   = S_MEM;
                        end else if (func == 5'd4) begin
                            aluOp = 2'b01;
                            if (zero) begin
                                pcWrite = 1'b1;
                                pcSrc   = 2'b01;
                            end
                            complete = 1'b1;
                        end else begin
                            complete = 1'b1;
                        end
                    end
                    INS_J: begin
                        if (func <= 5'd1) begin
                            pcWrite = 1'b1;
                            pcSrc   = 2'b01;
                            if (func == 5'd1) begin
                                regWrite = 1'b1;
                                wbSel    = 2'b10;
                            end
                        end
                        complete = 1'b1;
                    end
                    INS_S: begin
                        if (func <= 5'd3) begin
                            aluOp   = 2'b11;
                            aluSrcB = 1'b0;
                            state_d = S_WB;
                        end else begin
                            complete = 1'b1;
                        end
                    end
                    default: begin
                        complete = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                memReq   = 1'b1;
                memRead  = is_load_q;
                memWrite = !is_load_q;
                if (memAck) begin
                    if (is_load_q) begin
                        state_d = S_WB;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            S_WB: begin
                regWrite = 1'b1;
                wbSel    = is_load_q ? 2'b01 : 2'b00;
                complete = 1'b1;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (complete) begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = stop ? S_HALT : S_FETCH;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule
